// File: rtl/coriolis_pkg.sv
// Shared constants and helpers for the coriolis kernel output path.
package coriolis_pkg;

  localparam int unsigned STREAMW_DEF = 32;
  localparam int unsigned NELEM_DEF   = 64;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coriolis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
module coriolis_sync_fifo
  import coriolis_pkg::*;
#(
  parameter int unsigned WIDTH = STREAMW_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Same index with differing wrap bits means the write pointer lapped the read pointer.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/coriolis_ker0_ostream.sv
// Output-stream stage: elastic FIFO after sub6 plus per-frame word counting.
module coriolis_ker0_ostream
  import coriolis_pkg::*;
#(
  parameter int unsigned STREAMW = STREAMW_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NELEM   = NELEM_DEF,
  parameter int unsigned CNTW    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid,
  input  logic [STREAMW-1:0] in1,
  output logic               iready,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  input  logic               oready,
  output logic               olast,
  output logic               done,
  output logic [CNTW-1:0]    fcount
);

  localparam logic [CNTW-1:0] LAST    = CNTW'(NELEM - 1);
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic            init_q;
  logic            done_q;
  logic [CNTW-1:0] fcount_q, fcount_d;
  logic            full, empty, push, pop, at_last;

  // init_q keeps iready low until the first edge after reset release.
  assign iready  = init_q & ~full;
  assign push    = ivalid & iready;
  assign ovalid  = ~empty;
  assign pop     = ovalid & oready;
  assign at_last = (fcount_q == LAST);
  assign olast   = ovalid & at_last;
  assign done    = done_q;
  assign fcount  = fcount_q;

  coriolis_sync_fifo #(
    .WIDTH (STREAMW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in1),
    .pop   (pop),
    .rdata (out1),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    fcount_d = fcount_q;
    if (pop) fcount_d = at_last ? '0 : fcount_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      fcount_q <= '0;
    end else begin
      init_q   <= 1'b1;
      done_q   <= pop & at_last;
      fcount_q <= fcount_d;
    end
  end

endmodule

// File: tb/tb_coriolis_ker0_ostream.sv
// Randomised, self-checking bench for coriolis_ker0_ostream against a queue model.
module tb_coriolis_ker0_ostream;

  localparam int DEPTH = 4;
  localparam int NELEM = 6;
  localparam int CNTW  = 7;
  localparam int VW    = 3 + 32 + 2 + CNTW;

  logic            clk, rst, ivalid, oready;
  logic [31:0]     in1, out1;
  logic            iready, ovalid, olast, done;
  logic [CNTW-1:0] fcount;

  int checks = 0;
  int fails  = 0;

  // Behavioural model: a queue of words, a frame position and a pending-done flag.
  logic [31:0] mq[$];
  int          pos;
  bit          done_m, rdy_m;

  coriolis_ker0_ostream #(
    .STREAMW (32),
    .DEPTH   (DEPTH),
    .NELEM   (NELEM),
    .CNTW    (CNTW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ivalid (ivalid),
    .in1    (in1),
    .iready (iready),
    .ovalid (ovalid),
    .out1   (out1),
    .oready (oready),
    .olast  (olast),
    .done   (done),
    .fcount (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  function automatic logic [VW-1:0] exp_vec();
    logic        ev, er, el;
    logic [31:0] ed;
    ev = (mq.size() != 0);
    er = rdy_m && (mq.size() < DEPTH);
    ed = ev ? mq[0] : 32'h0;
    el = ev && (pos == NELEM - 1);
    return {er, ev, ed, el, done_m, CNTW'(pos)};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {iready, ovalid, out1, olast, done, fcount};
  endfunction

  task automatic model_reset();
    mq.delete();
    pos    = 0;
    done_m = 0;
    rdy_m  = 0;
  endtask

  // Drive one cycle from a negedge; update the model at the posedge; return at the next negedge.
  task automatic tick(input logic iv, input logic [31:0] d, input logic ordy, output bit acc);
    bit pp;
    ivalid = iv;
    in1    = d;
    oready = ordy;
    acc    = rst && rdy_m && iv && (mq.size() < DEPTH);
    pp     = rst && (mq.size() != 0) && ordy;
    @(posedge clk);
    if (rst) begin
      done_m = pp && (pos == NELEM - 1);
      if (pp) begin
        void'(mq.pop_front());
        pos = (pos + 1) % NELEM;
      end
      if (acc) mq.push_back(d);
      rdy_m = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bit acc;
    rst = 1'b0;
    ivalid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(1'b0, 32'h0, 1'b0, acc);
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b0; ivalid = 1'b1; in1 = 32'hDEAD_BEEF; oready = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({iready, ovalid, done, olast, fcount, out1} !== {4'b0, {CNTW{1'b0}}, 32'h0}) begin
        fails++;
        $display("FAIL reset_hold: got iready=%b ovalid=%b done=%b olast=%b fcount=%0d out1=%h want all 0",
                 iready, ovalid, done, olast, fcount, out1);
      end
    end
    ivalid = 1'b0;
    rst = 1'b1;
    tick(1'b0, 32'h0, 1'b0, acc);
    checks++;
    if (iready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_iready: got %b want 1", iready);
    end
  endtask

  task automatic test_stream();
    bit acc;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stream_vec: got %h want %h", obs_vec(), exp_vec());
      end
      checks++;
      if (iready !== 1'b1) begin
        fails++;
        $display("FAIL stream_iready: got %b want 1", iready);
      end
      tick(i < 8, 32'h10 + i, 1'b1, acc);
      if (i < 8) begin
        checks++;
        if (ovalid !== 1'b1 || out1 !== 32'h10 + i) begin
          fails++;
          $display("FAIL stream_latency: got ovalid=%b out1=%h want 1 %h", ovalid, out1, 32'h10 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit          acc;
    int          idx;
    logic [31:0] got[$];
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL bp_hold_vec: got %h want %h", obs_vec(), exp_vec());
      end
      tick(idx < 6, 32'hA0 + idx, 1'b0, acc);
      if (acc) idx++;
    end
    checks++;
    if (iready !== 1'b0 || ovalid !== 1'b1 || out1 !== 32'hA0) begin
      fails++;
      $display("FAIL bp_full: got iready=%b ovalid=%b out1=%h want 0 1 a0", iready, ovalid, out1);
    end
    for (int c = 0; c < 30 && got.size() < 6; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL bp_drain_vec: got %h want %h", obs_vec(), exp_vec());
      end
      if (ovalid) got.push_back(out1);
      tick(idx < 6, 32'hA0 + idx, 1'b1, acc);
      if (acc) idx++;
    end
    checks++;
    if (got.size() != 6) begin
      fails++;
      $display("FAIL bp_count: got %0d words want 6", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== 32'hA0 + k) begin
        fails++;
        $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], 32'hA0 + k);
      end
    end
  endtask

  task automatic test_frame();
    bit acc;
    int npop;
    bit last_prev;
    do_reset();
    npop = 0;
    last_prev = 0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL frame_vec: got %h want %h", obs_vec(), exp_vec());
      end
      checks++;
      if (done !== last_prev) begin
        fails++;
        $display("FAIL frame_done: got %b want %b after pop %0d", done, last_prev, npop);
      end
      last_prev = 0;
      if (ovalid) begin
        npop++;
        checks++;
        if (olast !== ((npop % NELEM) == 0)) begin
          fails++;
          $display("FAIL frame_olast: got %b want %b on word %0d", olast, (npop % NELEM) == 0, npop);
        end
        last_prev = ((npop % NELEM) == 0);
      end
      tick(i < 13, 32'h300 + i, 1'b1, acc);
    end
    checks++;
    if (npop != 13 || fcount !== CNTW'(1)) begin
      fails++;
      $display("FAIL frame_end: got words=%0d fcount=%0d want 13 1", npop, fcount);
    end
  endtask

  task automatic test_random();
    bit          acc, iv, ordy, prev_hold;
    logic [31:0] prev_out, d;
    logic [31:0] sb[$];
    int          recv, occ, sent;
    recv = 0; occ = 0; sent = 0; prev_hold = 0; prev_out = 0;
    for (int c = 0; c < 20000 && recv < 1000; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL rand_vec: got %h want %h", obs_vec(), exp_vec());
      end
      if (prev_hold) begin
        checks++;
        if (out1 !== prev_out) begin
          fails++;
          $display("FAIL rand_stable: got %h want %h", out1, prev_out);
        end
      end
      iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = $urandom;
      if (ovalid && ordy) begin
        checks++;
        if (sb.size() == 0 || out1 !== sb[0]) begin
          fails++;
          $display("FAIL rand_order: got %h want %h", out1, (sb.size() != 0) ? sb[0] : 32'hx);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        recv++;
        occ--;
      end
      if (iv && iready) begin
        sb.push_back(d);
        sent++;
        occ++;
      end
      checks++;
      if (occ > DEPTH) begin
        fails++;
        $display("FAIL rand_occupancy: got %0d want <= %0d", occ, DEPTH);
      end
      prev_hold = ovalid && !ordy;
      prev_out  = out1;
      tick(iv, d, ordy, acc);
    end
    checks++;
    if (recv != 1000) begin
      fails++;
      $display("FAIL rand_timeout: got %0d words want 1000", recv);
    end
  endtask

  task automatic test_midreset();
    bit acc;
    logic [2:0] ivs [5];
    logic [2:0] ors [5];
    do_reset();
    ivs = '{1, 1, 1, 1, 1};
    ors = '{0, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL mid_fill_vec: got %h want %h", obs_vec(), exp_vec());
      end
      tick(ivs[i][0], 32'h500 + i, ors[i][0], acc);
    end
    checks++;
    if (fcount !== CNTW'(2) || ovalid !== 1'b1 || out1 !== 32'h502) begin
      fails++;
      $display("FAIL mid_prestate: got fcount=%0d ovalid=%b out1=%h want 2 1 502", fcount, ovalid, out1);
    end
    oready = 1'b0;
    ivalid = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (ovalid !== 1'b0 || fcount !== '0 || olast !== 1'b0 || iready !== 1'b0) begin
      fails++;
      $display("FAIL mid_async: got ovalid=%b fcount=%0d olast=%b iready=%b want 0 0 0 0",
               ovalid, fcount, olast, iready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1'b0, 32'h0, 1'b0, acc);
    checks++;
    if (ovalid !== 1'b0 || out1 !== 32'h0) begin
      fails++;
      $display("FAIL mid_stale: got ovalid=%b out1=%h want 0 0", ovalid, out1);
    end
    tick(1'b1, 32'h77, 1'b0, acc);
    checks++;
    if (ovalid !== 1'b1 || out1 !== 32'h77 || fcount !== '0) begin
      fails++;
      $display("FAIL mid_restart: got ovalid=%b out1=%h fcount=%0d want 1 77 0", ovalid, out1, fcount);
    end
    tick(1'b0, 32'h0, 1'b1, acc);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL mid_drain_vec: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    rst = 1'b0; ivalid = 1'b0; in1 = '0; oready = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_frame();
    test_random();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
